button_event_decoder: RTL

Input-side counterpart to the display path: conditions the raw range-hood buttons (left, right, on/off) into clean single-cycle events for the power controller. Each button is synchronised and debounced. The on/off button is classified as a short or long press. A left→right or right→left sequence within a window is decoded into a gesture-on or gesture-off pulse. Sits between the board pins and the on/off controller in the top level.

---
 rtl/button_event_decoder.sv | 129 ++++++++++++
 1 files changed

// File: rtl/button_event_decoder.sv
// button_event_decoder: synchronise/debounce buttons, classify on/off presses, decode left/right gestures.
// Define BTN_DEC_LONG_PRESS_EN to build long-press detection on the on/off button.
module button_event_decoder #(
  parameter int DEBOUNCE_CYCLES   = 2_000_000,
  parameter int LONG_PRESS_CYCLES = 300_000_000,
  parameter int GESTURE_WINDOW    = 500_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left_btn,
  input  logic       right_btn,
  input  logic       on_off_btn,
  output logic       left_level,
  output logic       right_level,
  output logic       on_off_level,
  output logic       on_off_short,
  output logic       on_off_long,
  output logic       gesture_on,
  output logic       gesture_off,
  output logic [1:0] gesture_state
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DMAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] WMAX = 32'(GESTURE_WINDOW - 1);
  typedef enum logic [1:0] {IDLE = 2'b00, LEFT_ARMED = 2'b01, RIGHT_ARMED = 2'b10} state_t;
  logic [2:0] raw, s1, s2, level, level_q;
  logic lp, rp, rel, gon_n, goff_n;
  state_t state, nstate;
  logic [31:0] win, nwin;
  assign raw = {on_off_btn, right_btn, left_btn};
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
      level_q <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      level_q <= level;
    end
  for (genvar b = 0; b < 3; b++) begin : g_db
    logic [CW-1:0] cnt;
    logic lv;
    always_ff @(posedge clk or negedge reset)
      if (!reset) begin
        cnt <= '0;
        lv <= 1'b0;
      end else if (s2[b] == lv) cnt <= '0;
      else if (cnt == DMAX) begin
        cnt <= '0;
        lv <= ~lv;
      end else cnt <= cnt + 1'b1;
    assign level[b] = lv;
  end
  assign left_level = level[0];
  assign right_level = level[1];
  assign on_off_level = level[2];
  assign lp = level[0] & ~level_q[0];
  assign rp = level[1] & ~level_q[1];
  assign rel = ~level[2] & level_q[2];
`ifdef BTN_DEC_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [HW-1:0] HMAX = HW'(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] HLONG = HW'(LONG_PRESS_CYCLES - 1);
  logic [HW-1:0] hold;
  logic long_seen;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      hold <= '0;
      long_seen <= 1'b0;
      on_off_short <= 1'b0;
      on_off_long <= 1'b0;
    end else begin
      on_off_short <= rel & ~long_seen;
      on_off_long <= level[2] & (hold == HLONG) & ~long_seen;
      if (!level[2]) begin
        hold <= '0;
        long_seen <= 1'b0;
      end else begin
        hold <= (hold == HMAX) ? hold : hold + 1'b1;
        long_seen <= long_seen | (hold == HLONG);
      end
    end
`else
  assign on_off_long = 1'b0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) on_off_short <= 1'b0;
    else on_off_short <= rel;
`endif
  // A completing press is checked before re-arm and expiry so it always wins.
  always_comb begin
    nstate = state;
    nwin = win + 1'b1;
    gon_n = 1'b0;
    goff_n = 1'b0;
    case (state)
      IDLE: begin
        nwin = '0;
        nstate = (lp & ~rp) ? LEFT_ARMED : (rp & ~lp) ? RIGHT_ARMED : IDLE;
      end
      LEFT_ARMED:
        if (rp) begin
          gon_n = 1'b1;
          nstate = IDLE;
        end else if (lp) nwin = '0;
        else if (win == WMAX) nstate = IDLE;
      RIGHT_ARMED:
        if (lp) begin
          goff_n = 1'b1;
          nstate = IDLE;
        end else if (rp) nwin = '0;
        else if (win == WMAX) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      win <= '0;
      gesture_on <= 1'b0;
      gesture_off <= 1'b0;
    end else begin
      state <= nstate;
      win <= nwin;
      gesture_on <= gon_n;
      gesture_off <= goff_n;
    end
  assign gesture_state = state;
endmodule
